hack_cpu_ctrl: RTL and testbench



---
 rtl/hack_pkg.sv | 36 +++
 rtl/hack_jump_unit.sv | 20 ++
 rtl/hack_cpu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control stage: FSM encoding,
// instruction field positions and dest/jump bit indices.
package hack_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned CTRL_W = 6;

   // Instruction field positions
   localparam int unsigned IR_CTYPE   = 15;
   localparam int unsigned IR_A       = 12;
   localparam int unsigned IR_C_HI    = 11;
   localparam int unsigned IR_C_LO    = 6;
   localparam int unsigned IR_DEST_HI = 5;
   localparam int unsigned IR_DEST_LO = 3;
   localparam int unsigned IR_JMP_HI  = 2;
   localparam int unsigned IR_JMP_LO  = 0;

   // Bit indices inside the 3-bit dest field {A,D,M}
   localparam int unsigned DEST_A = 2;
   localparam int unsigned DEST_D = 1;
   localparam int unsigned DEST_M = 0;

   // Bit indices inside the 3-bit jump field {lt,eq,gt}
   localparam int unsigned JMP_LT = 2;
   localparam int unsigned JMP_EQ = 1;
   localparam int unsigned JMP_GT = 0;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_MRD    = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MWR    = 3'd4
   } state_t;

endpackage

// File: rtl/hack_jump_unit.sv
// Jump decision from the {lt,eq,gt} jump bits and the ALU zr/ng flags.
//   jmp    : {lt,eq,gt} field of the C-instruction
//   zr, ng : ALU zero / negative flags
//   take_c : combinational jump-taken decision
module hack_jump_unit
   import hack_pkg::*;
(
   input  logic [2:0] jmp,
   input  logic       zr,
   input  logic       ng,
   output logic       take_c
);

   always_comb begin
      take_c = (jmp[JMP_LT] & ng) |
               (jmp[JMP_EQ] & zr) |
               (jmp[JMP_GT] & ~ng & ~zr);
   end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control/datapath stage feeding an external ALU.
// Holds A, D, PC, IR, MDR; fetches via imem req/ack and accesses data
// memory via dmem req/ack, so wait-state memories are supported.
//   imem_*  : instruction fetch handshake (addr = PC)
//   dmem_*  : data read (a=1 operand) / write (dest M) handshake
//   alu_*   : operands/control to the ALU and its result/flags back
//   retire  : one-cycle pulse per completed instruction
//   pc      : current PC (debug)
module hack_cpu_ctrl
   import hack_pkg::*;
#(
   parameter int unsigned         ADDR_W   = 15,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0
)(
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [WORD_W-1:0]   imem_rdata,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic [WORD_W-1:0]   dmem_wdata,
   input  logic                dmem_ack,
   input  logic [WORD_W-1:0]   dmem_rdata,
   output logic [WORD_W-1:0]   alu_x,
   output logic [WORD_W-1:0]   alu_y,
   output logic [CTRL_W-1:0]   alu_ctrl,
   input  logic [WORD_W-1:0]   alu_out,
   input  logic                alu_zr,
   input  logic                alu_ng,
   output logic                retire,
   output logic [ADDR_W-1:0]   pc
);

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   a_q, a_d;
   logic [WORD_W-1:0]   d_q, d_d;
   logic [WORD_W-1:0]   ir_q, ir_d;
   logic [WORD_W-1:0]   mdr_q, mdr_d;
   logic [ADDR_W-1:0]   pc_d;
   logic [ADDR_W-1:0]   daddr_d;
   logic [WORD_W-1:0]   wdata_d;
   logic [WORD_W-1:0]   alu_y_d;
   logic                imem_req_d, dmem_req_d, dmem_we_d, retire_d;
   logic [2:0]          dest_c;
   logic                take_c;

   assign dest_c    = ir_q[IR_DEST_HI:IR_DEST_LO];
   assign imem_addr = pc;
   assign alu_x     = d_q;
   assign alu_ctrl  = ir_q[IR_C_HI:IR_C_LO];

   hack_jump_unit u_jump (
      .jmp    (ir_q[IR_JMP_HI:IR_JMP_LO]),
      .zr     (alu_zr),
      .ng     (alu_ng),
      .take_c (take_c)
   );

   // Next-state and next-register values
   always_comb begin
      state_d  = state_q;
      pc_d     = pc;
      a_d      = a_q;
      d_d      = d_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      daddr_d  = dmem_addr;
      wdata_d  = dmem_wdata;
      retire_d = 1'b0;

      case (state_q)
         ST_FETCH: begin
            if (imem_req && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!ir_q[IR_CTYPE]) begin
               a_d      = ir_q;
               pc_d     = pc + ADDR_W'(1);
               retire_d = 1'b1;
               state_d  = ST_FETCH;
            end else if (ir_q[IR_A]) begin
               daddr_d  = a_q[ADDR_W-1:0];
               state_d  = ST_MRD;
            end else begin
               state_d  = ST_EXEC;
            end
         end
         ST_MRD: begin
            if (dmem_req && dmem_ack) begin
               mdr_d   = dmem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // Write address and jump target both use A before this write
            if (dest_c[DEST_D]) d_d = alu_out;
            if (dest_c[DEST_A]) a_d = alu_out;
            daddr_d = a_q[ADDR_W-1:0];
            wdata_d = alu_out;
            pc_d    = take_c ? a_q[ADDR_W-1:0] : pc + ADDR_W'(1);
            if (dest_c[DEST_M]) begin
               state_d = ST_MWR;
            end else begin
               retire_d = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         ST_MWR: begin
            if (dmem_req && dmem_ack) begin
               retire_d = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      // Requests follow the state being entered so they are registered
      imem_req_d = (state_d == ST_FETCH);
      dmem_req_d = (state_d == ST_MRD) || (state_d == ST_MWR);
      dmem_we_d  = (state_d == ST_MWR);
      alu_y_d    = ir_d[IR_A] ? mdr_d : a_d;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc         <= RESET_PC;
         a_q        <= '0;
         d_q        <= '0;
         ir_q       <= '0;
         mdr_q      <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         alu_y      <= '0;
         retire     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc         <= pc_d;
         a_q        <= a_d;
         d_q        <= d_d;
         ir_q       <= ir_d;
         mdr_q      <= mdr_d;
         imem_req   <= imem_req_d;
         dmem_req   <= dmem_req_d;
         dmem_we    <= dmem_we_d;
         dmem_addr  <= daddr_d;
         dmem_wdata <= wdata_d;
         alu_y      <= alu_y_d;
         retire     <= retire_d;
      end
   end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: external Hack ALU, ROM/RAM with configurable wait
// states, and an instruction-level Hack reference model checked at retire.
module tb_hack_cpu_ctrl;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                imem_req, imem_ack;
   logic [ADDR_W-1:0]   imem_addr;
   logic [15:0]         imem_rdata;
   logic                dmem_req, dmem_we, dmem_ack;
   logic [ADDR_W-1:0]   dmem_addr;
   logic [15:0]         dmem_wdata, dmem_rdata;
   logic [15:0]         alu_x, alu_y, alu_out;
   logic [5:0]          alu_ctrl;
   logic                alu_zr, alu_ng, retire;
   logic [ADDR_W-1:0]   pc;

   always #5 clk = ~clk;

   hack_cpu_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(15'd0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
      .retire(retire), .pc(pc)
   );

   // Hack ALU as defined by the ISA
   function automatic logic [15:0] alu_f(input logic [5:0] c, input logic [15:0] x,
                                         input logic [15:0] y);
      logic [15:0] xx, yy, o;
      xx = c[5] ? 16'h0000 : x;
      if (c[4]) xx = ~xx;
      yy = c[3] ? 16'h0000 : y;
      if (c[2]) yy = ~yy;
      o = c[1] ? xx + yy : xx & yy;
      if (c[0]) o = ~o;
      return o;
   endfunction

   assign alu_out = alu_f(alu_ctrl, alu_x, alu_y);
   assign alu_zr  = (alu_out == 16'h0000);
   assign alu_ng  = alu_out[15];

   // Memories
   logic [15:0] rom      [DEPTH];
   logic [15:0] ram      [DEPTH];
   logic [15:0] ram_init [DEPTH];
   int          wmode = 0;           // <0: random 0..3 wait cycles
   int          icnt, itgt, dcnt, dtgt;
   int          wr_cnt = 0;
   logic [ADDR_W-1:0] last_waddr;
   logic [15:0]       last_wdata;

   function automatic int pick();
      if (wmode < 0) return int'($urandom_range(3, 0));
      return wmode;
   endfunction

   assign imem_ack   = imem_req && (icnt >= itgt);
   assign imem_rdata = rom[imem_addr];
   assign dmem_ack   = dmem_req && (dcnt >= dtgt);
   assign dmem_rdata = ram[dmem_addr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icnt <= 0;
         itgt <= pick();
      end else if (imem_req) begin
         if (imem_ack) begin
            icnt <= 0;
            itgt <= pick();
         end else begin
            icnt <= icnt + 1;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt <= 0;
         dtgt <= pick();
         for (int i = 0; i < DEPTH; i++) ram[i] <= ram_init[i];
      end else if (dmem_req) begin
         if (dmem_ack) begin
            dcnt <= 0;
            dtgt <= pick();
            if (dmem_we) begin
               ram[dmem_addr] <= dmem_wdata;
               last_waddr     <= dmem_addr;
               last_wdata     <= dmem_wdata;
               wr_cnt         <= wr_cnt + 1;
            end
         end else begin
            dcnt <= dcnt + 1;
         end
      end
   end

   // Reference model state and checker bookkeeping
   int                nvec = 0, nerr = 0, nret = 0, seen = 0;
   logic [ADDR_W-1:0] m_pc;
   logic [15:0]       m_a, m_d, m_mdr;
   logic [15:0]       mram [DEPTH];
   logic              p_ireq, p_iack, p_dreq, p_dack, p_dwe;
   logic [ADDR_W-1:0] p_iaddr, p_daddr;
   logic [15:0]       p_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Execute one instruction on the model and compare retire-time outputs
   task automatic model_step();
      logic [15:0]       ins, y, o;
      logic [ADDR_W-1:0] waddr, npc;
      logic              take;
      ins = rom[m_pc];
      if (!ins[15]) begin
         m_a  = ins;
         m_pc = m_pc + 15'd1;
         chk("no_write", 32'(wr_cnt), 32'(seen));
      end else begin
         y = ins[12] ? mram[m_a[ADDR_W-1:0]] : m_a;
         if (ins[12]) m_mdr = y;
         o     = alu_f(ins[11:6], m_d, y);
         take  = (ins[2] && o[15]) || (ins[1] && o == 16'h0) ||
                 (ins[0] && !o[15] && o != 16'h0);
         waddr = m_a[ADDR_W-1:0];
         npc   = take ? m_a[ADDR_W-1:0] : m_pc + 15'd1;
         if (ins[5]) m_a = o;
         if (ins[4]) m_d = o;
         if (ins[3]) begin
            mram[waddr] = o;
            chk("write_count", 32'(wr_cnt), 32'(seen + 1));
            chk("write_addr_data", {1'b0, last_waddr, last_wdata}, {1'b0, waddr, o});
         end else begin
            chk("no_write", 32'(wr_cnt), 32'(seen));
         end
         m_pc = npc;
      end
      seen = wr_cnt;
      chk("pc", 32'(pc), 32'(m_pc));
      chk("alu_x_D", 32'(alu_x), 32'(m_d));
      chk("alu_y", 32'(alu_y), 32'(ins[12] ? m_mdr : m_a));
      chk("alu_ctrl", 32'(alu_ctrl), 32'(ins[11:6]));
   endtask

   // One clock: sample at negedge, check handshakes, step model on retire
   task automatic tick();
      @(negedge clk);
      if (!rst_n) begin
         m_pc = 15'd0; m_a = 16'h0; m_d = 16'h0; m_mdr = 16'h0;
         for (int i = 0; i < DEPTH; i++) mram[i] = ram_init[i];
         p_ireq = 1'b0; p_dreq = 1'b0; p_iack = 1'b0; p_dack = 1'b0;
         nret = 0;
         seen = wr_cnt;
         return;
      end
      if (p_ireq && !p_iack)
         chk("imem_hold", {16'h0, imem_req, imem_addr}, {16'h0, 1'b1, p_iaddr});
      if (p_dreq && !p_dack)
         chk("dmem_hold", {dmem_req, dmem_we, dmem_addr, dmem_wdata},
                          {1'b1, p_dwe, p_daddr, p_wdata});
      if (retire) begin
         nret++;
         model_step();
      end
      p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr;
      p_dreq = dmem_req; p_dack = dmem_ack; p_dwe = dmem_we;
      p_daddr = dmem_addr; p_wdata = dmem_wdata;
   endtask

   task automatic run_until(input int n, input int budget);
      int c = 0;
      while (nret < n && c < budget) begin
         tick();
         c++;
      end
      if (nret < n) chk("retire_timeout", 32'(nret), 32'(n));
   endtask

   // Hold reset over a few clocks with the currently loaded images
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < DEPTH; i++) begin
         rom[i] = 16'h0000;
         ram_init[i] = 16'h0000;
      end
   endtask

   task automatic load_prog1();
      clear_mem();
      rom[0] = 16'h0005;   // @5
      rom[1] = 16'hEC10;   // D=A
      rom[2] = 16'h0003;   // @3
      rom[3] = 16'hE090;   // D=D+A
      rom[4] = 16'h0000;   // @0
      rom[5] = 16'hE308;   // M=D
   endtask

   task automatic prog1_check(input string tag);
      run_until(6, 200);
      chk({tag, "_pc"}, 32'(pc), 32'd6);
      chk({tag, "_D"}, 32'(alu_x), 32'd8);
      chk({tag, "_A"}, 32'(alu_y), 32'd0);
      chk({tag, "_ram0"}, 32'(ram[0]), 32'd8);
   endtask

   initial begin
      int c;
      // Test 1: zero-wait memory
      wmode = 0;
      load_prog1();
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_reqs", {29'h0, imem_req, dmem_req, dmem_we}, 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_D", 32'(alu_x), 32'd0);
      tick();
      rst_n = 1'b1;
      prog1_check("t1");

      // Test 2: three wait cycles per access
      wmode = 3;
      load_prog1();
      do_reset();
      prog1_check("t2");

      // Test 3: JLT taken with D=-1, not taken with D=0
      wmode = 0;
      clear_mem();
      rom[0] = 16'h000A; rom[1] = 16'hEE90; rom[2] = 16'h0014; rom[3] = 16'hE304;
      do_reset();
      run_until(4, 100);
      chk("t3_jlt_taken_pc", 32'(pc), 32'd20);
      rom[1] = 16'hEA90;
      do_reset();
      run_until(4, 100);
      chk("t3_jlt_fall_pc", 32'(pc), 32'd4);

      // Test 4: AM=M+1 writes old A; AD=A;JMP uses old A
      wmode = -1;
      clear_mem();
      ram_init[7] = 16'h1234;
      rom[0] = 16'h0007; rom[1] = 16'hFDE8; rom[2] = 16'hEC10;
      rom[3] = 16'h0004; rom[4] = 16'hEC37;
      do_reset();
      run_until(2, 100);
      chk("t4_ram7", 32'(ram[7]), 32'h1235);
      run_until(3, 100);
      chk("t4_D_eq_A", 32'(alu_x), 32'h1235);
      run_until(5, 100);
      chk("t4_jmp_pc", 32'(pc), 32'd4);
      chk("t4_A", 32'(alu_y), 32'd4);
      chk("t4_D", 32'(alu_x), 32'd4);

      // Test 5: PC wrap from 0x7FFF
      wmode = 0;
      clear_mem();
      rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[15'h7FFF] = 16'h0001;
      do_reset();
      run_until(2, 100);
      chk("t5_pc_top", 32'(pc), 32'h7FFF);
      run_until(3, 100);
      chk("t5_pc_wrap", 32'(pc), 32'd0);
      chk("t5_A", 32'(alu_y), 32'd1);

      // Test 6: reset asserted during a write access
      wmode = 3;
      load_prog1();
      do_reset();
      c = 0;
      while (!(dmem_req && dmem_we) && c < 300) begin
         tick();
         c++;
      end
      chk("t6_reached_mwr", {30'h0, dmem_req, dmem_we}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_dmem_req_drop", {30'h0, dmem_req, imem_req}, 32'd0);
      chk("t6_pc", 32'(pc), 32'd0);
      chk("t6_D", 32'(alu_x), 32'd0);
      chk("t6_A", 32'(alu_y), 32'd0);
      chk("t6_ram0_untouched", 32'(ram[0]), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      c = 0;
      while (!imem_req && c < 20) begin
         tick();
         c++;
      end
      chk("t6_first_fetch", {16'h0, imem_req, imem_addr}, {16'h0, 1'b1, 15'd0});
      prog1_check("t6");

      // Randomized programs against the reference model
      wmode = -1;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            rom[i]      = 16'($urandom);
            ram_init[i] = 16'($urandom);
         end
         do_reset();
         run_until(400, 6000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
